// File: rtl/sram_ctrl_pkg.sv
// Shared definitions for the SRAM arbiter: FSM state encoding and default bus widths.
package sram_ctrl_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: one-hot grant from the request pair and a
// priority pointer that moves away from whichever requester was last granted.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       Reset,
  input  logic [1:0] req_i,
  input  logic       upd_i,
  output logic [1:0] gnt_o
);

  // ptr_q = 0 favours requester 0 on a tie, 1 favours requester 1
  logic ptr_q, ptr_d;

  always_comb begin
    gnt_o = 2'b00;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = ptr_q ? 2'b10 : 2'b01;
      default: gnt_o = 2'b00;
    endcase
    ptr_d = ptr_q;
    if (upd_i && (gnt_o != 2'b00)) ptr_d = gnt_o[0];
  end

  always_ff @(posedge clk) begin
    if (Reset) ptr_q <= 1'b0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/sram_arbiter.sv
// Shares one single-port SRAM between two requesters, one transaction at a time,
// with registered strobes/address/data and per-requester completion pulses.
module sram_arbiter #(
  parameter int ADDR_W = sram_ctrl_pkg::ADDR_W,
  parameter int DATA_W = sram_ctrl_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              done0,
  output logic              done1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              busy,
  output logic              SRAMRead,
  output logic              SRAMWrite,
  output logic [ADDR_W-1:0] Address,
  output logic [DATA_W-1:0] Datain,
  input  logic [DATA_W-1:0] Dataout
);

  import sram_ctrl_pkg::*;

  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic              we_q, we_d;
  logic              rd_q, rd_d, wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic [1:0]        arb_gnt;
  logic              arb_upd;

  rr_arbiter2 u_arb (
    .clk   (clk),
    .Reset (Reset),
    .req_i ({req1, req0}),
    .upd_i (arb_upd),
    .gnt_o (arb_gnt)
  );

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    we_d     = we_q;
    addr_d   = addr_q;
    din_d    = din_q;
    rd_d     = 1'b0;
    wr_d     = 1'b0;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    arb_upd  = 1'b0;
    gnt0     = 1'b0;
    gnt1     = 1'b0;
    case (state_q)
      IDLE: begin
        // Grant is suppressed while Reset is high so nothing is accepted and lost
        if (!Reset && (arb_gnt != 2'b00)) begin
          arb_upd = 1'b1;
          gnt0    = arb_gnt[0];
          gnt1    = arb_gnt[1];
          owner_d = arb_gnt[1];
          we_d    = arb_gnt[1] ? we1    : we0;
          addr_d  = arb_gnt[1] ? addr1  : addr0;
          din_d   = arb_gnt[1] ? wdata1 : wdata0;
          rd_d    = !we_d;
          wr_d    = we_d;
          state_d = ACCESS;
        end
      end
      ACCESS: state_d = we_q ? DONE : WAIT;
      WAIT: begin
        if (owner_q) rdata1_d = Dataout;
        else         rdata0_d = Dataout;
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      we_q     <= 1'b0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      din_q    <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      we_q     <= we_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      din_q    <= din_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  assign done0     = (state_q == DONE) && !owner_q;
  assign done1     = (state_q == DONE) &&  owner_q;
  assign busy      = (state_q != IDLE);
  assign SRAMRead  = rd_q;
  assign SRAMWrite = wr_q;
  assign Address   = addr_q;
  assign Datain    = din_q;
  assign rdata0    = rdata0_q;
  assign rdata1    = rdata1_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter with a behavioural SRAM behind it.
module tb_sram_arbiter;

  logic       clk = 1'b0;
  logic       Reset;
  logic       req0, req1, we0, we1;
  logic [7:0] addr0, addr1, wdata0, wdata1;
  logic       gnt0, gnt1, done0, done1, busy, SRAMRead, SRAMWrite;
  logic [7:0] rdata0, rdata1, Address, Datain, Dataout;

  always #5 clk = ~clk;

  sram_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk(clk), .Reset(Reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .rdata0(rdata0), .rdata1(rdata1), .busy(busy),
    .SRAMRead(SRAMRead), .SRAMWrite(SRAMWrite),
    .Address(Address), .Datain(Datain), .Dataout(Dataout)
  );

  // SRAM model: read data appears the cycle after SRAMRead
  logic [7:0] mem [256];
  always @(posedge clk) begin
    if (SRAMWrite) mem[Address] <= Datain;
    if (SRAMRead)  Dataout      <= mem[Address];
  end

  typedef struct packed {
    logic gnt0, gnt1, done0, done1, busy, rd, wr;
    logic [7:0] addr, din, rd0, rd1;
  } snap_t;

  typedef struct packed {
    logic       gport, dport, we;
    logic [7:0] addr, data;
  } obs_t;

  snap_t      s;
  obs_t       pend;
  obs_t       obs_q[$];
  obs_t       exp_q[$];
  logic [7:0] ref_mem [256];
  int         viol = 0;
  int         gnt1_cnt = 0;
  int         checks = 0;
  int         errors = 0;

  // One clock: sample at the falling edge, rebuild observed transactions,
  // then return 1 time unit after the next rising edge for driving.
  task automatic tick();
    @(negedge clk);
    s.gnt0 = gnt0; s.gnt1 = gnt1; s.done0 = done0; s.done1 = done1;
    s.busy = busy; s.rd = SRAMRead; s.wr = SRAMWrite;
    s.addr = Address; s.din = Datain; s.rd0 = rdata0; s.rd1 = rdata1;
    if ((s.rd && s.wr) || (s.gnt0 && s.gnt1) || (s.done0 && s.done1)) viol++;
    if (s.gnt1) gnt1_cnt++;
    if (s.gnt0 || s.gnt1) begin pend = '0; pend.gport = s.gnt1; end
    if (s.wr) begin pend.we = 1'b1; pend.addr = s.addr; pend.data = s.din; end
    if (s.rd) begin pend.we = 1'b0; pend.addr = s.addr; end
    if (s.done0 || s.done1) begin
      pend.dport = s.done1;
      if (!pend.we) pend.data = s.done1 ? s.rd1 : s.rd0;
      obs_q.push_back(pend);
    end
    @(posedge clk); #1;
  endtask

  task automatic expect_txn(input logic port, input logic we, input logic [7:0] a, input logic [7:0] d);
    obs_t e;
    e.gport = port; e.dport = port; e.we = we; e.addr = a;
    if (we) begin e.data = d; ref_mem[a] = d; end
    else    e.data = ref_mem[a];
    exp_q.push_back(e);
  endtask

  task automatic set_req(input logic port, input logic we, input logic [7:0] a, input logic [7:0] d);
    if (port) begin req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d; end
    else      begin req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d; end
  endtask

  // Behaves like well-mannered requesters: drop reqN the cycle after gntN,
  // except requester 0 keeps asserting when hold0 is set.
  task automatic serve(input int ngnt, input bit hold0, output int got);
    got = 0;
    for (int c = 0; c < 100 && got < ngnt; c++) begin
      tick();
      if (s.gnt0 || s.gnt1) got++;
      if (s.gnt1) req1 = 1'b0;
      if (s.gnt0 && (!hold0 || got >= ngnt)) req0 = 1'b0;
    end
    req0 = 1'b0; req1 = 1'b0;
  endtask

  task automatic sb_check(input string name);
    int   n;
    int   c;
    obs_t a, e;
    n = exp_q.size();
    c = 0;
    while (obs_q.size() < n && c < 60) begin tick(); c++; end
    checks++;
    if (obs_q.size() < n) begin
      errors++;
      $display("FAIL %s: timeout, %0d of %0d transactions completed", name, obs_q.size(), n);
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      a = obs_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL %s: got gnt%0d/done%0d we=%0d addr=%0h data=%0h, expected port %0d we=%0d addr=%0h data=%0h",
                 name, a.gport, a.dport, a.we, a.addr, a.data, e.gport, e.we, e.addr, e.data);
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d unexpected completed transactions", name, obs_q.size());
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic pulse_reset();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    tick();
    tick();
    Reset = 1'b0;
    tick();
    checks++;
    if ({s.gnt0, s.gnt1, s.done0, s.done1, s.busy, s.rd, s.wr} !== 7'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b, expected 0000000", {s.gnt0, s.gnt1, s.done0, s.done1, s.busy, s.rd, s.wr});
    end
    checks++;
    if (s.addr !== 8'h00 || s.din !== 8'h00) begin
      errors++; $display("FAIL reset_bus: Address=%0h Datain=%0h, expected 0 0", s.addr, s.din);
    end
    checks++;
    if (s.rd0 !== 8'h00 || s.rd1 !== 8'h00) begin
      errors++; $display("FAIL reset_rdata: rdata0=%0h rdata1=%0h, expected 0 0", s.rd0, s.rd1);
    end
  endtask

  task automatic test_write();
    set_req(1'b0, 1'b1, 8'd5, 8'hA5);
    expect_txn(1'b0, 1'b1, 8'd5, 8'hA5);
    tick();
    checks++;
    if (!(s.gnt0 === 1'b1 && s.gnt1 === 1'b0 && s.busy === 1'b0)) begin
      errors++; $display("FAIL write_gnt: gnt0=%b gnt1=%b busy=%b, expected 1 0 0", s.gnt0, s.gnt1, s.busy);
    end
    req0 = 1'b0;
    tick();
    checks++;
    if (!(s.wr === 1'b1 && s.rd === 1'b0 && s.addr === 8'd5 && s.din === 8'hA5 && s.busy === 1'b1)) begin
      errors++; $display("FAIL write_strobe: wr=%b rd=%b addr=%0h din=%0h busy=%b, expected 1 0 5 a5 1", s.wr, s.rd, s.addr, s.din, s.busy);
    end
    tick();
    checks++;
    if (!(s.done0 === 1'b1 && s.done1 === 1'b0 && s.wr === 1'b0 && s.busy === 1'b1)) begin
      errors++; $display("FAIL write_done: done0=%b done1=%b wr=%b busy=%b, expected 1 0 0 1", s.done0, s.done1, s.wr, s.busy);
    end
    tick();
    checks++;
    if (s.busy !== 1'b0 || s.done0 !== 1'b0 || s.addr !== 8'd5) begin
      errors++; $display("FAIL write_idle: busy=%b done0=%b addr=%0h, expected 0 0 5", s.busy, s.done0, s.addr);
    end
    sb_check("write_sb");
  endtask

  task automatic test_read();
    set_req(1'b1, 1'b0, 8'd5, 8'h00);
    expect_txn(1'b1, 1'b0, 8'd5, 8'h00);
    tick();
    checks++;
    if (!(s.gnt1 === 1'b1 && s.gnt0 === 1'b0)) begin
      errors++; $display("FAIL read_gnt: gnt1=%b gnt0=%b, expected 1 0", s.gnt1, s.gnt0);
    end
    req1 = 1'b0;
    tick();
    checks++;
    if (!(s.rd === 1'b1 && s.wr === 1'b0 && s.addr === 8'd5)) begin
      errors++; $display("FAIL read_strobe: rd=%b wr=%b addr=%0h, expected 1 0 5", s.rd, s.wr, s.addr);
    end
    tick();
    checks++;
    if (!(s.done1 === 1'b0 && s.rd === 1'b0 && s.busy === 1'b1)) begin
      errors++; $display("FAIL read_wait: done1=%b rd=%b busy=%b, expected 0 0 1", s.done1, s.rd, s.busy);
    end
    tick();
    checks++;
    if (!(s.done1 === 1'b1 && s.rd1 === 8'hA5 && s.rd0 === 8'h00)) begin
      errors++; $display("FAIL read_done: done1=%b rdata1=%0h rdata0=%0h, expected 1 a5 0", s.done1, s.rd1, s.rd0);
    end
    tick();
    checks++;
    if (!(s.busy === 1'b0 && s.rd1 === 8'hA5)) begin
      errors++; $display("FAIL read_hold: busy=%b rdata1=%0h, expected 0 a5", s.busy, s.rd1);
    end
    sb_check("read_sb");
  endtask

  task automatic test_round_robin();
    int got;
    pulse_reset();
    set_req(1'b0, 1'b1, 8'd10, 8'h3C);
    set_req(1'b1, 1'b1, 8'd20, 8'h77);
    expect_txn(1'b0, 1'b1, 8'd10, 8'h3C);
    expect_txn(1'b1, 1'b1, 8'd20, 8'h77);
    serve(2, 1'b0, got);
    checks++;
    if (got !== 2) begin errors++; $display("FAIL rr_wr_grants: got %0d grants, expected 2", got); end
    sb_check("rr_write_sb");
    set_req(1'b0, 1'b0, 8'd10, 8'h00);
    set_req(1'b1, 1'b0, 8'd20, 8'h00);
    expect_txn(1'b0, 1'b0, 8'd10, 8'h00);
    expect_txn(1'b1, 1'b0, 8'd20, 8'h00);
    serve(2, 1'b0, got);
    checks++;
    if (got !== 2) begin errors++; $display("FAIL rr_rd_grants: got %0d grants, expected 2", got); end
    sb_check("rr_read_sb");
  endtask

  task automatic test_back_to_back();
    int got;
    pulse_reset();
    set_req(1'b0, 1'b1, 8'd30, 8'h11);
    set_req(1'b1, 1'b1, 8'd31, 8'h22);
    expect_txn(1'b0, 1'b1, 8'd30, 8'h11);
    expect_txn(1'b1, 1'b1, 8'd31, 8'h22);
    expect_txn(1'b0, 1'b1, 8'd30, 8'h11);
    serve(3, 1'b1, got);
    checks++;
    if (got !== 3) begin errors++; $display("FAIL hold_grants: got %0d grants, expected 3", got); end
    sb_check("hold_sb");
  endtask

  task automatic test_reset_mid();
    int got;
    set_req(1'b0, 1'b0, 8'd10, 8'h00);
    expect_txn(1'b0, 1'b0, 8'd10, 8'h00);
    serve(1, 1'b0, got);
    sb_check("pre_reset_sb");
    set_req(1'b1, 1'b0, 8'd10, 8'h00);
    tick();
    req1 = 1'b0;
    tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    tick();
    checks++;
    if ({s.gnt0, s.gnt1, s.done0, s.done1, s.busy, s.rd, s.wr} !== 7'b0 || s.addr !== 8'h00 ||
        s.din !== 8'h00 || s.rd0 !== 8'h00 || s.rd1 !== 8'h00) begin
      errors++; $display("FAIL mid_reset_state: ctrl=%b addr=%0h din=%0h rdata0=%0h rdata1=%0h, expected all 0",
                         {s.gnt0, s.gnt1, s.done0, s.done1, s.busy, s.rd, s.wr}, s.addr, s.din, s.rd0, s.rd1);
    end
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (obs_q.size() != 0) begin
      errors++; $display("FAIL mid_reset_done: %0d completions seen, expected 0", obs_q.size());
    end
    obs_q.delete();
    set_req(1'b1, 1'b0, 8'd20, 8'h00);
    expect_txn(1'b1, 1'b0, 8'd20, 8'h00);
    serve(1, 1'b0, got);
    sb_check("post_reset_sb");
  endtask

  task automatic test_withdraw();
    int g1;
    set_req(1'b0, 1'b0, 8'd20, 8'h00);
    expect_txn(1'b0, 1'b0, 8'd20, 8'h00);
    tick();
    req0 = 1'b0;
    g1 = gnt1_cnt;
    set_req(1'b1, 1'b0, 8'd30, 8'h00);
    tick();
    tick();
    req1 = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (gnt1_cnt !== g1) begin
      errors++; $display("FAIL withdraw_gnt: %0d gnt1 pulses, expected 0", gnt1_cnt - g1);
    end
    sb_check("withdraw_sb");
  endtask

  initial begin
    Reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    pend = '0;
    test_reset();
    test_write();
    test_read();
    test_round_robin();
    test_back_to_back();
    test_reset_mid();
    test_withdraw();
    checks++;
    if (viol !== 0) begin
      errors++; $display("FAIL exclusivity: %0d cycles with two strobes/grants/dones high, expected 0", viol);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
